// File: rtl/dev_hex_mux.sv
// rtl/dev_hex_mux.sv - multiplexed hex 7-segment driver with per-frame input snapshot,
// leading-zero suppression, blanking and per-slot PWM brightness.
module dev_hex_mux #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex_val,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg_pins,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_start
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [PCW-1:0]      pcnt_q, pcnt_d;
  logic [3:0]          t_q, t_d;
  logic [SW-1:0]       s_q, s_d;
  logic [4*DIGITS-1:0] hex_sh_q;
  logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                lz_sh_q;
  logic [3:0]          bri_sh_q;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                fs_q;
  logic                tick, load;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick   = (pcnt_q == PCW'(PRESCALE - 1));
    load   = (pcnt_q == '0) && (t_q == 4'h0) && (s_q == '0);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    t_d    = tick ? t_q + 4'h1 : t_q;
    s_d    = s_q;
    if (tick && (t_q == 4'hF)) begin
      s_d = (s_q == SW'(DIGITS - 1)) ? '0 : s_q + 1'b1;
    end
  end

  // Digit i is suppressed when it and every more significant nibble are zero.
  logic [DIGITS-1:0] sup;
  logic              zero_run;
  always_comb begin
    sup      = '0;
    zero_run = lz_sh_q;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (hex_sh_q[4*i +: 4] == 4'h0);
      if (i != 0) sup[i] = zero_run;
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, cur_sup;
  logic [DIGITS-1:0] onehot;
  logic [3:0]        bri_eff;
  logic              guard, lit;
  logic [7:0]        seg_act;
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_q == SW'(i)) begin
        cur_nib   = hex_sh_q[4*i +: 4];
        cur_dp    = dp_sh_q[i];
        cur_blank = blank_sh_q[i];
        cur_sup   = sup[i];
        onehot[i] = 1'b1;
      end
    end
    bri_eff = (bri_sh_q >= 4'd14) ? 4'd14 : bri_sh_q;
    guard   = (t_q == 4'h0) || (t_q == 4'hF);
    lit     = !guard && (t_q <= bri_eff);
    seg_act = 8'h00;
    if (lit && !cur_blank) begin
      seg_act = {cur_dp, cur_sup ? 7'h00 : font(cur_nib)};
    end
    seg_d = seg_act ^ SEG_INV;
    dig_d = (guard ? '0 : onehot) ^ DIG_INV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q     <= '0;
      t_q        <= 4'h0;
      s_q        <= '0;
      hex_sh_q   <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      lz_sh_q    <= 1'b0;
      bri_sh_q   <= 4'h0;
      seg_q      <= SEG_INV;
      dig_q      <= DIG_INV;
      fs_q       <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      t_q    <= t_d;
      s_q    <= s_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      fs_q   <= load;
      if (load) begin
        hex_sh_q   <= hex_val;
        dp_sh_q    <= dp;
        blank_sh_q <= blank_mask;
        lz_sh_q    <= lz_suppress;
        bri_sh_q   <= brightness;
      end
    end
  end

  assign seg_pins    = seg_q;
  assign dig_en      = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_dev_hex_mux.sv
// tb/tb_dev_hex_mux.sv - directed self-checking bench for dev_hex_mux (DIGITS=4, PRESCALE=1).
module tb_dev_hex_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hex_val = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic [7:0]  seg_pins;
  logic [3:0]  dig_en;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_a [64];
  logic [3:0] dig_a [64];
  logic       fs_a  [64];

  dev_hex_mux #(
    .DIGITS(4), .PRESCALE(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .hex_val(hex_val), .dp(dp), .blank_mask(blank_mask),
    .lz_suppress(lz_suppress), .brightness(brightness), .seg_pins(seg_pins),
    .dig_en(dig_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the negedge after the loading clock: frame position 0.
  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic capture_frame();
    for (int k = 0; k < 64; k++) begin
      seg_a[k] = seg_pins;
      dig_a[k] = dig_en;
      fs_a[k]  = frame_start;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    hex_val = 16'($urandom); dp = 4'($urandom); blank_mask = 4'($urandom);
    lz_suppress = 1'($urandom); brightness = 4'($urandom);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (seg_pins !== 8'hFF || dig_en !== 4'h0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: seg=%h dig=%b fs=%b want FF 0000 0", i, seg_pins, dig_en, frame_start);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'h0 || seg_pins !== 8'hFF) begin
      errors++;
      $display("FAIL reset_first_load: fs=%b dig=%b seg=%h want 1 0000 FF", frame_start, dig_en, seg_pins);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs_pulse: fs=%b want 0", frame_start);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_seg [4];
    exp_seg[0] = 8'h8E; exp_seg[1] = 8'h88; exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
    hex_val = 16'h12AF; dp = 4'h0; blank_mask = 4'h0; lz_suppress = 1'b0; brightness = 4'd14;
    reset_dut();
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 16; t++) begin
        checks++;
        if (t == 0 || t == 15) begin
          if (dig_a[16*s+t] !== 4'h0 || seg_a[16*s+t] !== 8'hFF) begin
            errors++;
            $display("FAIL basic_guard s%0d t%0d: dig=%b seg=%h want 0000 FF", s, t, dig_a[16*s+t], seg_a[16*s+t]);
          end
        end else if (dig_a[16*s+t] !== (4'b0001 << s) || seg_a[16*s+t] !== exp_seg[s]) begin
          errors++;
          $display("FAIL basic_slot s%0d t%0d: dig=%b seg=%h want %b %h", s, t, dig_a[16*s+t], seg_a[16*s+t], 4'b0001 << s, exp_seg[s]);
        end
      end
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (fs_a[k] !== (k == 0)) begin
        errors++;
        $display("FAIL basic_fs k%0d: fs=%b want %b", k, fs_a[k], k == 0);
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL basic_fs_period: fs=%b want 1 at clk 64", frame_start);
    end
  endtask

  task automatic test_lz();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a[0] = 8'hC0; exp_a[1] = 8'h92; exp_a[2] = 8'h7F; exp_a[3] = 8'hFF;
    exp_b[0] = 8'hC0; exp_b[1] = 8'hFF; exp_b[2] = 8'hFF; exp_b[3] = 8'hFF;
    hex_val = 16'h0050; dp = 4'b0100; blank_mask = 4'h0; lz_suppress = 1'b1; brightness = 4'd14;
    reset_dut();
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_a[16*s+5] !== exp_a[s] || dig_a[16*s+5] !== (4'b0001 << s)) begin
        errors++;
        $display("FAIL lz_0050 digit %0d: seg=%h dig=%b want %h %b", s, seg_a[16*s+5], dig_a[16*s+5], exp_a[s], 4'b0001 << s);
      end
    end
    hex_val = 16'h0000; dp = 4'h0;
    reset_dut();
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_a[16*s+9] !== exp_b[s]) begin
        errors++;
        $display("FAIL lz_zero digit %0d: seg=%h want %h", s, seg_a[16*s+9], exp_b[s]);
      end
    end
  endtask

  task automatic test_brightness();
    logic [7:0] want;
    hex_val = 16'h12AF; dp = 4'h0; blank_mask = 4'h0; lz_suppress = 1'b0; brightness = 4'd3;
    reset_dut();
    capture_frame();
    for (int t = 1; t < 15; t++) begin
      want = (t <= 3) ? 8'h8E : 8'hFF;
      checks++;
      if (seg_a[t] !== want || dig_a[t] !== 4'b0001) begin
        errors++;
        $display("FAIL bri3 t%0d: seg=%h dig=%b want %h 0001", t, seg_a[t], dig_a[t], want);
      end
    end
    brightness = 4'd0;
    reset_dut();
    capture_frame();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (seg_a[k] !== 8'hFF) begin
        errors++;
        $display("FAIL bri0 k%0d: seg=%h want FF", k, seg_a[k]);
      end
    end
    brightness = 4'd15;
    reset_dut();
    capture_frame();
    checks++;
    if (seg_a[14] !== 8'h8E || seg_a[15] !== 8'hFF || seg_a[1] !== 8'h8E) begin
      errors++;
      $display("FAIL bri15: t1=%h t14=%h t15=%h want 8E 8E FF", seg_a[1], seg_a[14], seg_a[15]);
    end
  endtask

  task automatic test_tear_free();
    hex_val = 16'h1111; dp = 4'h0; blank_mask = 4'h0; lz_suppress = 1'b0; brightness = 4'd14;
    reset_dut();
    for (int k = 0; k < 128; k++) begin
      if (k == 24) hex_val = 16'h2222;
      if ((k % 16) != 0 && (k % 16) != 15) begin
        checks++;
        if (seg_pins !== ((k < 64) ? 8'hF9 : 8'hA4)) begin
          errors++;
          $display("FAIL tear k%0d: seg=%h want %h", k, seg_pins, (k < 64) ? 8'hF9 : 8'hA4);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mask_reset();
    hex_val = 16'h12AF; dp = 4'b1111; blank_mask = 4'b0010; lz_suppress = 1'b0; brightness = 4'd14;
    reset_dut();
    capture_frame();
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (seg_a[16+t] !== 8'hFF) begin
        errors++;
        $display("FAIL mask_digit1 t%0d: seg=%h want FF", t, seg_a[16+t]);
      end
    end
    checks++;
    if (seg_a[3] !== 8'h0E || dig_a[20] !== 4'b0010) begin
      errors++;
      $display("FAIL mask_neighbours: d0=%h dig_s1=%b want 0E 0010", seg_a[3], dig_a[20]);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (dig_en !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_pre: dig=%b want 0100", dig_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (seg_pins !== 8'hFF || dig_en !== 4'h0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_inactive: seg=%h dig=%b fs=%b want FF 0000 0", seg_pins, dig_en, frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'h0) begin
      errors++;
      $display("FAIL midrst_load: fs=%b dig=%b want 1 0000", frame_start, dig_en);
    end
    @(negedge clk);
    checks++;
    if (dig_en !== 4'b0001 || seg_pins !== 8'h0E || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_slot0: dig=%b seg=%h fs=%b want 0001 0E 0", dig_en, seg_pins, frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_brightness();
    test_tear_free();
    test_mask_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
